// File: rtl/mips_mult_seq_pkg.sv
// ============================================================================
//  Module   : mips_mult_seq_pkg
//  Purpose  : Shared MIPS defines for the sequential multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mult_seq_pkg;

    localparam int         DEFAULT_WIDTH = 32;
    localparam logic [5:0] OP0_MULT      = 6'h18;
    localparam logic [5:0] OP0_MULTU     = 6'h19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mult_state_e;

endpackage

`default_nettype wire

// File: rtl/mips_mult_seq_if.sv
// ============================================================================
//  Module   : mips_mult_seq_if
//  Purpose  : Request/result bundle between the pipeline and the multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_mult_seq_if
    import mips_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             signed_op;
    logic             cancel;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_op, cancel, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, signed_op, cancel, rs_data, rt_data,
        output busy, done, hi, lo
    );

endinterface

`default_nettype wire

// File: rtl/mips_mult_seq_datapath.sv
// ============================================================================
//  Module   : mult_acc_datapath
//  Purpose  : Shift-add accumulator, sign handling and hi/lo result registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_acc_datapath
    import mips_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             fix_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic               neg_q,    neg_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;

    logic [WIDTH-1:0]   w_rs_abs;
    logic [WIDTH-1:0]   w_rt_abs;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_result;

    // Magnitudes are treated as unsigned, so -2^(WIDTH-1) maps onto itself correctly.
    assign w_rs_abs = (signed_i && rs_i[WIDTH-1]) ? (~rs_i + WIDTH'(1)) : rs_i;
    assign w_rt_abs = (signed_i && rt_i[WIDTH-1]) ? (~rt_i + WIDTH'(1)) : rt_i;

    // The carry-out lands in the top accumulator bit after the right shift.
    assign w_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign w_result = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (load_i) begin
            mcand_d  = w_rs_abs;
            mplier_d = w_rt_abs;
            acc_d    = '0;
            neg_d    = signed_i & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
        end else if (step_i) begin
            acc_d    = {w_sum, acc_q[WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
        end
        if (fix_i) begin
            hi_d = w_result[2*WIDTH-1:WIDTH];
            lo_d = w_result[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/mips_mult_seq.sv
// ============================================================================
//  Module   : mips_mult_seq
//  Purpose  : Sequential MULT/MULTU unit: control FSM and iteration counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mult_seq
    import mips_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_mult_seq_if.slave       bus_io
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;

    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_fix   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A simultaneous cancel drops the request.
                if (bus_io.start && !bus_io.cancel) begin
                    w_load  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus_io.cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus_io.cancel) begin
                    w_fix  = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    mult_acc_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_load),
        .step_i   (w_step),
        .fix_i    (w_fix),
        .signed_i (bus_io.signed_op),
        .rs_i     (bus_io.rs_data),
        .rt_i     (bus_io.rt_data),
        .hi_o     (w_hi),
        .lo_o     (w_lo)
    );

    assign bus_io.busy = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign bus_io.done = done_q;
    assign bus_io.hi   = w_hi;
    assign bus_io.lo   = w_lo;

endmodule

`default_nettype wire
